// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the divider slice.
// FDIV_RADIX4_EN selects two quotient bits per cycle.
package fpu_pkg;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
  } float32_t;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int QBITS    = 26;

`ifdef FDIV_RADIX4_EN
  localparam int ITERS = 13;
`else
  localparam int ITERS = 26;
`endif

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    DONE
  } fdiv_state_e;

endpackage

// File: rtl/fdiv_mant_step.sv
// One restoring division step on the mantissa remainder.
// Produces one quotient bit and the shifted next remainder.
module fdiv_mant_step (
  input  logic [24:0] rem,
  input  logic [23:0] dvsr,
  output logic [24:0] rem_nxt,
  output logic        q_bit
);

  logic [24:0] diff;

  // Remainder stays below the divisor, so the shift never drops a set bit.
  always_comb begin
    q_bit   = (rem >= {1'b0, dvsr});
    diff    = q_bit ? rem - {1'b0, dvsr} : rem;
    rem_nxt = {diff[23:0], 1'b0};
  end

endmodule

// File: rtl/fdiv_iterative.sv
// Iterative binary32 divider, y = x1 / x2, fixed latency.
// Define FDIV_RADIX4_EN to retire two quotient bits per cycle.
module fdiv_iterative (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf,
  output logic        unf,
  output logic        valid
);

  import fpu_pkg::*;

  float32_t a;
  float32_t b;

  fdiv_state_e state;

  logic [4:0]        cnt;
  logic              sgn;
  logic              z1;
  logic              z2;
  logic signed [9:0] expo;
  logic [23:0]       dvsr;
  logic [24:0]       rem;
  logic [QBITS-1:0]  q;
  logic [22:0]       mant;

  logic [24:0]       rem_a;
  logic              qa;
  logic [24:0]       rem_n;
  logic [QBITS-1:0]  q_n;

  logic [22:0]       mant_t;
  logic              r_bit;
  logic [23:0]       mant_s;
  logic signed [9:0] exp_t;
  logic signed [9:0] exp_n;

  assign a = x1;
  assign b = x2;

  fdiv_mant_step u_step0 (
    .rem     (rem),
    .dvsr    (dvsr),
    .rem_nxt (rem_a),
    .q_bit   (qa)
  );

`ifdef FDIV_RADIX4_EN
  logic [24:0] rem_b;
  logic        qb;

  fdiv_mant_step u_step1 (
    .rem     (rem_a),
    .dvsr    (dvsr),
    .rem_nxt (rem_b),
    .q_bit   (qb)
  );

  assign rem_n = rem_b;
  assign q_n   = {q[QBITS-3:0], qa, qb};
`else
  assign rem_n = rem_a;
  assign q_n   = {q[QBITS-2:0], qa};
`endif

  // Quotient lies in [0.5, 2): pick the window by the integer bit.
  always_comb begin
    mant_t = q[23:1];
    r_bit  = q[0];
    exp_t  = expo - 10'sd1;
    if (q[QBITS-1]) begin
      mant_t = q[24:2];
      r_bit  = q[1];
      exp_t  = expo;
    end
    mant_s = {1'b0, mant_t} + {23'd0, r_bit};
    exp_n  = mant_s[23] ? exp_t + 10'sd1 : exp_t;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      valid    <= 1'b0;
      y        <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      cnt      <= '0;
      sgn      <= 1'b0;
      z1       <= 1'b0;
      z2       <= 1'b0;
      expo     <= '0;
      dvsr     <= '0;
      rem      <= '0;
      q        <= '0;
      mant     <= '0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sgn      <= a.s ^ b.s;
            z1       <= (a.e == 8'd0);
            z2       <= (b.e == 8'd0);
            expo     <= $signed({2'b00, a.e})
                      - $signed({2'b00, b.e})
                      + 10'(EXP_BIAS);
            dvsr     <= {1'b1, b.m};
            rem      <= {2'b01, a.m};
            q        <= '0;
            cnt      <= 5'(ITERS - 1);
            in_ready <= 1'b0;
            state    <= DIV;
          end
        end
        DIV: begin
          rem <= rem_n;
          q   <= q_n;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= NORM;
        end
        NORM: begin
          mant  <= mant_s[22:0];
          expo  <= exp_n;
          state <= DONE;
        end
        DONE: begin
          valid    <= 1'b1;
          in_ready <= 1'b1;
          state    <= IDLE;
          ovf      <= 1'b0;
          unf      <= 1'b0;
          if (z2) begin
            y   <= {sgn, 8'hFF, 23'd0};
            ovf <= 1'b1;
          end else if (z1) begin
            y <= {sgn, 31'd0};
          end else if (expo >= 10'(EXP_MAX)) begin
            y   <= {sgn, 8'hFF, 23'd0};
            ovf <= 1'b1;
          end else if (expo <= 10'sd0) begin
            y   <= {sgn, 31'd0};
            unf <= 1'b1;
          end else begin
            y <= {sgn, expo[7:0], mant};
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_iterative.sv
// Directed bench for fdiv_iterative; honours FDIV_RADIX4_EN.
module tb_fdiv_iterative;

`ifdef FDIV_RADIX4_EN
  localparam int LAT = 15;
`else
  localparam int LAT = 28;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x1 = '0;
  logic [31:0] x2 = '0;
  logic [31:0] y;
  logic        ovf;
  logic        unf;
  logic        valid;

  int total = 0;
  int bad   = 0;

  fdiv_iterative dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x1       (x1),
    .x2       (x2),
    .y        (y),
    .ovf      (ovf),
    .unf      (unf),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ry, output logic ro,
                       output logic ru, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    x1 = a;
    x2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = -1;
    ry  = 'x;
    ro  = 1'bx;
    ru  = 1'bx;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = k;
        ry  = y;
        ro  = ovf;
        ru  = unf;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b exp=0", valid);
    end
    total++;
    if (y !== 32'h0) begin
      bad++; $display("FAIL reset_y got=%h exp=00000000", y);
    end
    total++;
    if ({ovf, unf} !== 2'b00) begin
      bad++; $display("FAIL reset_flags got=%b%b exp=00", ovf, unf);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] ry;
    logic ro, ru;
    int lat;
    do_op(32'h40C00000, 32'h40000000, ry, ro, ru, lat);
    total++;
    if (ry !== 32'h40400000) begin
      bad++; $display("FAIL six_div_two_y got=%h exp=40400000", ry);
    end
    total++;
    if ({ro, ru} !== 2'b00) begin
      bad++; $display("FAIL six_div_two_flags got=%b%b exp=00", ro, ru);
    end
    total++;
    if (lat !== LAT) begin
      bad++; $display("FAIL six_div_two_latency got=%0d exp=%0d", lat, LAT);
    end
    @(posedge clk);
    #1;
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL valid_one_cycle got=%b exp=0", valid);
    end
  endtask

  task automatic test_round;
    logic [31:0] ry;
    logic ro, ru;
    int lat;
    do_op(32'h3F800000, 32'h40400000, ry, ro, ru, lat);
    total++;
    if (ry !== 32'h3EAAAAAB) begin
      bad++; $display("FAIL one_third_y got=%h exp=3eaaaaab", ry);
    end
    total++;
    if ({ro, ru} !== 2'b00) begin
      bad++; $display("FAIL one_third_flags got=%b%b exp=00", ro, ru);
    end
    total++;
    if (lat !== LAT) begin
      bad++; $display("FAIL one_third_latency got=%0d exp=%0d", lat, LAT);
    end
  endtask

  task automatic test_special;
    logic [31:0] ry;
    logic ro, ru;
    int lat;
    do_op(32'h3F800000, 32'h00000000, ry, ro, ru, lat);
    total++;
    if (ry !== 32'h7F800000) begin
      bad++; $display("FAIL div_zero_y got=%h exp=7f800000", ry);
    end
    total++;
    if ({ro, ru} !== 2'b10) begin
      bad++; $display("FAIL div_zero_flags got=%b%b exp=10", ro, ru);
    end
    total++;
    if (lat !== LAT) begin
      bad++; $display("FAIL div_zero_latency got=%0d exp=%0d", lat, LAT);
    end
    do_op(32'h80000000, 32'h40000000, ry, ro, ru, lat);
    total++;
    if (ry !== 32'h80000000) begin
      bad++; $display("FAIL zero_div_y got=%h exp=80000000", ry);
    end
    total++;
    if ({ro, ru} !== 2'b00) begin
      bad++; $display("FAIL zero_div_flags got=%b%b exp=00", ro, ru);
    end
  endtask

  task automatic test_range;
    logic [31:0] ry;
    logic ro, ru;
    int lat;
    do_op(32'h7F000000, 32'h00800000, ry, ro, ru, lat);
    total++;
    if (ry !== 32'h7F800000) begin
      bad++; $display("FAIL overflow_y got=%h exp=7f800000", ry);
    end
    total++;
    if ({ro, ru} !== 2'b10) begin
      bad++; $display("FAIL overflow_flags got=%b%b exp=10", ro, ru);
    end
    do_op(32'h00800000, 32'h7F000000, ry, ro, ru, lat);
    total++;
    if (ry !== 32'h00000000) begin
      bad++; $display("FAIL underflow_y got=%h exp=00000000", ry);
    end
    total++;
    if ({ro, ru} !== 2'b01) begin
      bad++; $display("FAIL underflow_flags got=%b%b exp=01", ro, ru);
    end
    total++;
    if (lat !== LAT) begin
      bad++; $display("FAIL underflow_latency got=%0d exp=%0d", lat, LAT);
    end
  endtask

  task automatic test_back_to_back;
    logic busy_rdy;
    logic [31:0] ry;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    x1 = 32'h40C00000;
    x2 = 32'h40000000;
    @(posedge clk);
    #1;
    x1 = 32'h3F800000;
    x2 = 32'h40400000;
    busy_rdy = 1'b0;
    lat = -1;
    ry = 'x;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = k;
        ry = y;
        break;
      end
      busy_rdy = busy_rdy | (in_ready !== 1'b0);
    end
    total++;
    if (busy_rdy !== 1'b0) begin
      bad++; $display("FAIL busy_in_ready got=%b exp=0", busy_rdy);
    end
    total++;
    if (lat !== LAT) begin
      bad++; $display("FAIL hs_first_latency got=%0d exp=%0d", lat, LAT);
    end
    total++;
    if (ry !== 32'h40400000) begin
      bad++; $display("FAIL hs_first_y got=%h exp=40400000", ry);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL hs_idle_ready got=%b exp=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL hs_second_accept got=%b exp=0", in_ready);
    end
    lat = -1;
    ry = 'x;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = k;
        ry = y;
        break;
      end
    end
    total++;
    if (lat !== LAT) begin
      bad++; $display("FAIL hs_second_latency got=%0d exp=%0d", lat, LAT);
    end
    total++;
    if (ry !== 32'h3EAAAAAB) begin
      bad++; $display("FAIL hs_second_y got=%h exp=3eaaaaab", ry);
    end
  endtask

  task automatic test_reset_midop;
    logic seen;
    logic [31:0] ry;
    logic ro, ru;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    x1 = 32'h3F800000;
    x2 = 32'h40400000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      seen = seen | valid;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL abort_in_ready got=%b exp=1", in_ready);
    end
    repeat (40) begin
      @(posedge clk);
      #1;
      seen = seen | valid;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL abort_no_valid got=%b exp=0", seen);
    end
    do_op(32'h40C00000, 32'h40000000, ry, ro, ru, lat);
    total++;
    if (ry !== 32'h40400000) begin
      bad++; $display("FAIL after_abort_y got=%h exp=40400000", ry);
    end
    total++;
    if (lat !== LAT) begin
      bad++; $display("FAIL after_abort_latency got=%0d exp=%0d", lat, LAT);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_round;
    test_special;
    test_range;
    test_back_to_back;
    test_reset_midop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
